// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader
// Brief   : Boot loader: byte stream -> LE 32-bit imem words, XOR check, core release
// Revision: 1.0
// ============================================================================
module imem_loader #(
   parameter int          DWIDTH    = 32,
   parameter int          DEPTH     = 256,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [31:0]       imem_addr,
   output logic [DWIDTH-1:0] imem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              error
);

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum logic [2:0] {
      S_LEN0 = 3'd0,
      S_LEN1 = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_RUN  = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [15:0] len;
   logic [15:0] word_cnt;
   logic [1:0]  byte_cnt;
   logic [7:0]  csum;
   logic [23:0] asm_lo;
   logic        accept;
   logic        word_done;
   logic [15:0] len_full;

   assign accept   = in_valid && in_ready;
   assign len_full = {in_data, len[7:0]};

   always_ff @(posedge clk) begin
      if (!rst) state <= S_LEN0;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      word_done = 1'b0;
      case (state)
         S_LEN0: if (accept) state_nx = S_LEN1;
         S_LEN1: begin
            if (accept) begin
               if (len_full == 16'd0)                  state_nx = S_CSUM;
               else if ({16'd0, len_full} > DEPTH_W)   state_nx = S_ERR;
               else                                    state_nx = S_DATA;
            end
         end
         S_DATA: begin
            if (accept && byte_cnt == 2'd3) begin
               word_done = 1'b1;
               if (word_cnt == len - 16'd1) state_nx = S_CSUM;
            end
         end
         S_CSUM: if (accept) state_nx = (in_data == csum) ? S_RUN : S_ERR;
         S_RUN, S_ERR: if (reload) state_nx = S_LEN0;
         default: state_nx = S_LEN0;
      endcase
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= ADDR_BASE;
         imem_wdata <= '0;
         core_rst   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         len        <= 16'd0;
         word_cnt   <= 16'd0;
         byte_cnt   <= 2'd0;
         csum       <= 8'd0;
         asm_lo     <= 24'd0;
      end else begin
         in_ready <= (state_nx != S_RUN) && (state_nx != S_ERR);
         core_rst <= (state_nx != S_RUN);
         done     <= (state_nx == S_RUN);
         error    <= (state_nx == S_ERR);
         imem_we  <= word_done;

         if (word_done) imem_wdata <= DWIDTH'({in_data, asm_lo});
         if (imem_we)   imem_addr  <= imem_addr + 32'd4;

         if (accept && (state == S_LEN0 || state == S_LEN1 || state == S_DATA))
            csum <= csum ^ in_data;
         if (accept && state == S_LEN0) len[7:0]  <= in_data;
         if (accept && state == S_LEN1) len[15:8] <= in_data;

         if (accept && state == S_DATA) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
               2'd0:    asm_lo[7:0]   <= in_data;
               2'd1:    asm_lo[15:8]  <= in_data;
               2'd2:    asm_lo[23:16] <= in_data;
               default: asm_lo        <= asm_lo;
            endcase
            if (word_done) word_cnt <= word_cnt + 16'd1;
         end

         if ((state == S_RUN || state == S_ERR) && reload) begin
            imem_addr <= ADDR_BASE;
            len       <= 16'd0;
            word_cnt  <= 16'd0;
            byte_cnt  <= 2'd0;
            csum      <= 8'd0;
         end
      end
   end

endmodule
`default_nettype wire
